// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with optional hard-wired zero entry,
// optional write-to-read forwarding and a saturating count of committed writes.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clr,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]       raddr1,
  input  logic [ADDR_W-1:0]       raddr2,
  output logic [WIDTH-1:0]        rdata1,
  output logic [WIDTH-1:0]        rdata2,
  output logic [15:0]             wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [15:0]       r_wr_cnt;
  logic              w_clear;
  logic              w_zero_waddr;
  logic              w_commit;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [WIDTH-1:0]  w_rdata [2];

  // rst_n is folded in so forwarding is dead while reset is held.
  assign w_clear      = enable & clr;
  assign w_zero_waddr = (ZERO_REG != 0) && (waddr == '0);
  assign w_commit     = rst_n & enable & ~clr & we & ~w_zero_waddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (w_clear) begin
      r_wr_cnt <= '0;
    end else if (w_commit && (r_wr_cnt != 16'hFFFF)) begin
      r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  // Zero entry wins over forwarding, forwarding wins over storage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic w_zero;
    logic w_fwd;
    assign w_zero      = (ZERO_REG != 0) && (w_raddr[gi] == '0);
    assign w_fwd       = (BYPASS != 0) && w_commit && (w_raddr[gi] == waddr);
    assign w_rdata[gi] = w_zero ? '0 : (w_fwd ? wdata : r_mem[w_raddr[gi]]);
  end

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];
  assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench: a forwarding and a non-forwarding instance share stimulus
// and are compared every cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_2r1w;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clr = 1'b0;
  logic we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic signed [W-1:0] wdata = '0;
  logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [15:0] cnt_b, cnt_n;

  logic [W-1:0] m_mem [N];
  int m_cnt = 0;
  int n_vec = 0;
  int n_err = 0;

  regfile_2r1w #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_b), .rdata2(rd2_b), .wr_cnt(cnt_b)
  );

  regfile_2r1w #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_n), .rdata2(rd2_n), .wr_cnt(cnt_n)
  );

  always #5 clk = ~clk;

  function automatic bit m_commit();
    return (rst_n === 1'b1) && enable && !clr && we && (waddr != '0);
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (rst_n !== 1'b1) return '0;
    if (a == '0) return '0;
    if (byp && m_commit() && (a == waddr)) return wdata;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_cnt = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit c, cl;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    if ((rst_n === 1'b1) && enable && !clr && we && $isunknown(waddr)) begin
      n_err++;
      $display("FAIL waddr_unknown got=%b required=known", waddr);
    end
    c  = m_commit();
    cl = (rst_n === 1'b1) && enable && clr;
    a  = waddr;
    d  = wdata;
    @(posedge clk);
    if (cl) m_reset();
    else if (c) begin
      m_mem[a] = d;
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4*W-1:0] got, exp;
    rst_n = 1'b0; enable = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 123;
    raddr1 = 5'd9; raddr2 = 5'd9;
    m_reset();
    repeat (3) begin
      #1;
      got = {rd1_b, rd2_b, rd1_n, rd2_n};
      n_vec++;
      if (got !== '0) begin
        n_err++;
        $display("FAIL reset_hold_read got=%h required=0", got);
      end
      tick();
    end
    rst_n = 1'b1; we = 1'b0;
    for (int a = 0; a < N; a++) begin
      raddr1 = AW'(a); raddr2 = AW'(N - 1 - a);
      #1;
      got = {rd1_b, rd2_b, rd1_n, rd2_n};
      exp = {m_read(raddr1, 1), m_read(raddr2, 1), m_read(raddr1, 0), m_read(raddr2, 0)};
      n_vec++;
      if (got !== exp || got !== '0) begin
        n_err++;
        $display("FAIL reset_sweep a=%0d got=%h required=%h", a, got, exp);
      end
      tick();
    end
    n_vec++;
    if (cnt_b !== 16'd0 || cnt_n !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt got=%0d/%0d required=0", cnt_b, cnt_n);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_readback();
    logic [4*W-1:0] got, exp;
    enable = 1'b1; clr = 1'b0;
    for (int k = 1; k < N; k++) begin
      we = 1'b1; waddr = AW'(k); wdata = 100 + k;
      raddr1 = AW'(k); raddr2 = AW'(k - 1);
      #1;
      got = {rd1_b, rd2_b, rd1_n, rd2_n};
      exp = {m_read(raddr1, 1), m_read(raddr2, 1), m_read(raddr1, 0), m_read(raddr2, 0)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL write_cycle k=%0d got=%h required=%h", k, got, exp);
      end
      tick();
    end
    we = 1'b0;
    for (int k = 1; k < N; k++) begin
      raddr1 = AW'(k); raddr2 = AW'(k);
      #1;
      n_vec++;
      if (rd1_b !== W'(100 + k) || rd2_b !== W'(100 + k) || rd1_n !== W'(100 + k)) begin
        n_err++;
        $display("FAIL readback k=%0d got=%0d/%0d/%0d required=%0d", k, rd1_b, rd2_b, rd1_n, 100 + k);
      end
    end
    n_vec++;
    if (cnt_b !== 16'd31 || cnt_n !== 16'd31) begin
      n_err++;
      $display("FAIL readback_cnt got=%0d/%0d required=31", cnt_b, cnt_n);
    end
    tick();
    we = 1'b1; waddr = '0; wdata = -7; raddr1 = '0; raddr2 = '0;
    #1;
    n_vec++;
    if (rd1_b !== '0 || rd2_b !== '0 || rd1_n !== '0) begin
      n_err++;
      $display("FAIL zero_bypass got=%h/%h/%h required=0", rd1_b, rd2_b, rd1_n);
    end
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if (rd1_b !== '0 || cnt_b !== 16'd31 || cnt_n !== 16'd31) begin
      n_err++;
      $display("FAIL zero_write got=%h cnt=%0d/%0d required=0 cnt=31", rd1_b, cnt_b, cnt_n);
    end
    $display("test_write_readback done");
  endtask

  task automatic test_bypass();
    enable = 1'b1; clr = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 10;
    tick();
    wdata = -42; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    n_vec++;
    if (rd1_b !== W'(-42) || rd2_b !== W'(-42) || rd1_n !== W'(10) || rd2_n !== W'(10)) begin
      n_err++;
      $display("FAIL bypass_pre got=%h/%h/%h/%h required=ffffffd6/ffffffd6/a/a", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if (rd1_b !== W'(-42) || rd1_n !== W'(-42) || rd2_n !== W'(-42)) begin
      n_err++;
      $display("FAIL bypass_post got=%h/%h/%h required=ffffffd6", rd1_b, rd1_n, rd2_n);
    end
    $display("test_bypass done");
  endtask

  task automatic test_enable_gating();
    logic [4*W-1:0] got, exp;
    int cnt0;
    cnt0 = m_cnt;
    enable = 1'b0; clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom_range(1)); waddr = AW'($urandom_range(N - 1));
      wdata = $urandom_range(99);
      raddr1 = waddr; raddr2 = AW'($urandom_range(N - 1));
      #1;
      got = {rd1_b, rd2_b, rd1_n, rd2_n};
      exp = {m_read(raddr1, 1), m_read(raddr2, 1), m_read(raddr1, 0), m_read(raddr2, 0)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL enable_gate i=%0d got=%h required=%h", i, got, exp);
      end
      tick();
    end
    n_vec++;
    if (cnt_b !== 16'(cnt0) || cnt_n !== 16'(cnt0)) begin
      n_err++;
      $display("FAIL enable_gate_cnt got=%0d/%0d required=%0d", cnt_b, cnt_n, cnt0);
    end
    $display("test_enable_gating done");
  endtask

  task automatic test_clear_priority();
    logic [4*W-1:0] got, exp;
    enable = 1'b1; clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 99;
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    got = {rd1_b, rd2_b, rd1_n, rd2_n};
    exp = {m_read(raddr1, 1), m_read(raddr2, 1), m_read(raddr1, 0), m_read(raddr2, 0)};
    n_vec++;
    if (got !== exp || rd1_b !== W'(103)) begin
      n_err++;
      $display("FAIL clr_no_bypass got=%h required=%h", got, exp);
    end
    tick();
    clr = 1'b0; we = 1'b0;
    #1;
    n_vec++;
    if (rd1_b !== '0 || rd2_n !== '0 || cnt_b !== 16'd0 || cnt_n !== 16'd0) begin
      n_err++;
      $display("FAIL clr_priority got=%h/%h cnt=%0d/%0d required=0", rd1_b, rd2_n, cnt_b, cnt_n);
    end
    we = 1'b1; wdata = 77;
    tick();
    enable = 1'b0; clr = 1'b1; we = 1'b0;
    tick();
    clr = 1'b0;
    #1;
    n_vec++;
    if (rd1_b !== W'(77) || rd1_n !== W'(77) || cnt_b !== 16'd1 || cnt_n !== 16'd1) begin
      n_err++;
      $display("FAIL clr_disabled got=%0d/%0d cnt=%0d/%0d required=77 cnt=1", rd1_b, rd1_n, cnt_b, cnt_n);
    end
    $display("test_clear_priority done");
  endtask

  task automatic test_async_reset();
    enable = 1'b1; clr = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 55;
    tick();
    we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    n_vec++;
    if (rd1_b !== W'(55) || rd1_n !== W'(55)) begin
      n_err++;
      $display("FAIL async_pre got=%0d/%0d required=55", rd1_b, rd1_n);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_vec++;
    if (rd1_b !== '0 || rd1_n !== '0 || cnt_b !== 16'd0 || cnt_n !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset got=%0d/%0d cnt=%0d/%0d required=0", rd1_b, rd1_n, cnt_b, cnt_n);
    end
    we = 1'b1; wdata = 66;
    #1;
    n_vec++;
    if (rd1_b !== '0 || rd2_b !== '0) begin
      n_err++;
      $display("FAIL async_no_bypass got=%h/%h required=0", rd1_b, rd2_b);
    end
    rst_n = 1'b1;
    tick();
    we = 1'b0;
    #1;
    n_vec++;
    if (rd1_b !== W'(66) || rd1_n !== W'(66) || cnt_b !== 16'd1 || cnt_n !== 16'd1) begin
      n_err++;
      $display("FAIL async_first_commit got=%0d/%0d cnt=%0d/%0d required=66 cnt=1", rd1_b, rd1_n, cnt_b, cnt_n);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [4*W-1:0] got, exp;
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(3) != 0);
      clr    = ($urandom_range(19) == 0);
      we     = ($urandom_range(9) < 6);
      waddr  = AW'($urandom_range(N - 1));
      wdata  = $urandom;
      raddr1 = $urandom_range(1) ? waddr : AW'($urandom_range(N - 1));
      raddr2 = $urandom_range(3) == 0 ? raddr1 : AW'($urandom_range(N - 1));
      #1;
      got = {rd1_b, rd2_b, rd1_n, rd2_n};
      exp = {m_read(raddr1, 1), m_read(raddr2, 1), m_read(raddr1, 0), m_read(raddr2, 0)};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_read i=%0d a1=%0d a2=%0d got=%h required=%h", i, raddr1, raddr2, got, exp);
      end
      n_vec++;
      if (cnt_b !== 16'(m_cnt) || cnt_n !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL random_cnt i=%0d got=%0d/%0d required=%0d", i, cnt_b, cnt_n, m_cnt);
      end
      tick();
    end
    clr = 1'b0; we = 1'b0;
    $display("test_random done");
  endtask

  task automatic test_saturation();
    enable = 1'b1; clr = 1'b1; we = 1'b0;
    tick();
    clr = 1'b0; we = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      waddr = AW'(1 + (i % 31)); wdata = i;
      tick();
    end
    n_vec++;
    if (cnt_b !== 16'hFFFF || cnt_n !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_reach got=%0d/%0d required=65535", cnt_b, cnt_n);
    end
    for (int i = 0; i < 5; i++) begin
      waddr = 5'd9; wdata = 1000 + i;
      tick();
    end
    we = 1'b0; raddr1 = 5'd9;
    #1;
    n_vec++;
    if (cnt_b !== 16'hFFFF || cnt_n !== 16'hFFFF || rd1_b !== W'(1004) || 16'(m_cnt) !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold got=%0d/%0d rd=%0d required=65535 rd=1004", cnt_b, cnt_n, rd1_b);
    end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_bypass();
    test_enable_gating();
    test_clear_priority();
    test_async_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
